// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with Start/Busy/Done handshake.
//   ADD, SUB, AND, OR and XOR complete one edge after Start is sampled; MUL is an
//   iterative shift-add unsigned multiply that takes WIDTH edges in the MUL state.
//
// Ports:
//   Clk        rising-edge clock
//   Rst_n      asynchronous active-low reset
//   Start      request, sampled only while idle
//   Op         000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR, 101 XOR, 110/111 invalid
//   OperA      operand A
//   OperB      operand B
//   Result     registered result, held until the next completion
//   Zero       Result == 0, registered with Result
//   Carry      ADD carry-out / SUB borrow / MUL upper product half nonzero
//   Overflow   signed overflow for ADD/SUB
//   Error      invalid opcode on the last completion
//   Busy       MUL in progress
//   Done       one-cycle completion pulse
module seq_alu #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] OperA,
   input  logic [WIDTH-1:0] OperB,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Carry,
   output logic             Overflow,
   output logic             Error,
   output logic             Busy,
   output logic             Done
);

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpMul = 3'b010;
   localparam logic [2:0] OpAnd = 3'b011;
   localparam logic [2:0] OpOr  = 3'b100;
   localparam logic [2:0] OpXor = 3'b101;

   // Counter value seen on the final MUL edge (it becomes WIDTH on that edge).
   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

   typedef enum logic [0:0] {
      StIdle,
      StMul
   } stateT;

   stateT                stateQ, stateD;
   logic [WIDTH-1:0]     mcandQ, mcandD;
   logic [WIDTH-1:0]     mplierQ, mplierD;
   logic [2*WIDTH-1:0]   accQ, accD;
   logic [CNT_W-1:0]     cntQ, cntD;
   logic [WIDTH-1:0]     resultQ, resultD;
   logic                 zeroQ, zeroD;
   logic                 carryQ, carryD;
   logic                 ovfQ, ovfD;
   logic                 errorQ, errorD;
   logic                 doneQ, doneD;

   logic                 isSub;
   logic [WIDTH-1:0]     bEff;
   logic [WIDTH:0]       sumExt;
   logic [2*WIDTH-1:0]   accNext;
   logic [WIDTH-1:0]     aluRes;

   // Shared adder: SUB is A + ~B + 1, carry-in supplied by isSub.
   assign isSub  = (Op == OpSub);
   assign bEff   = isSub ? ~OperB : OperB;
   assign sumExt = {1'b0, OperA} + {1'b0, bEff} + (WIDTH + 1)'(isSub);

   // Partial product for this iteration: multiplicand shifted by the counter.
   assign accNext = accQ + (mplierQ[0] ? ({{WIDTH{1'b0}}, mcandQ} << cntQ) : '0);

   always_comb begin
      stateD  = stateQ;
      mcandD  = mcandQ;
      mplierD = mplierQ;
      accD    = accQ;
      cntD    = cntQ;
      resultD = resultQ;
      zeroD   = zeroQ;
      carryD  = carryQ;
      ovfD    = ovfQ;
      errorD  = errorQ;
      doneD   = 1'b0;
      aluRes  = '0;

      unique case (stateQ)
         StIdle: begin
            if (Start) begin
               if (Op == OpMul) begin
                  mcandD  = OperA;
                  mplierD = OperB;
                  accD    = '0;
                  cntD    = '0;
                  stateD  = StMul;
               end else begin
                  carryD = 1'b0;
                  ovfD   = 1'b0;
                  errorD = 1'b0;
                  case (Op)
                     OpAdd: begin
                        aluRes = sumExt[WIDTH-1:0];
                        carryD = sumExt[WIDTH];
                        ovfD   = (OperA[WIDTH-1] == bEff[WIDTH-1]) &&
                                 (sumExt[WIDTH-1] != OperA[WIDTH-1]);
                     end
                     OpSub: begin
                        aluRes = sumExt[WIDTH-1:0];
                        carryD = ~sumExt[WIDTH];  // borrow
                        ovfD   = (OperA[WIDTH-1] == bEff[WIDTH-1]) &&
                                 (sumExt[WIDTH-1] != OperA[WIDTH-1]);
                     end
                     OpAnd:   aluRes = OperA & OperB;
                     OpOr:    aluRes = OperA | OperB;
                     OpXor:   aluRes = OperA ^ OperB;
                     default: errorD = 1'b1;
                  endcase
                  resultD = aluRes;
                  zeroD   = (aluRes == '0);
                  doneD   = 1'b1;
               end
            end
         end

         StMul: begin
            accD    = accNext;
            mplierD = mplierQ >> 1;
            cntD    = cntQ + CNT_W'(1);
            if (cntQ == LastCnt) begin
               resultD = accNext[WIDTH-1:0];
               zeroD   = (accNext[WIDTH-1:0] == '0);
               carryD  = |accNext[2*WIDTH-1:WIDTH];
               ovfD    = 1'b0;
               errorD  = 1'b0;
               doneD   = 1'b1;
               stateD  = StIdle;
            end
         end

         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         stateQ  <= StIdle;
         mcandQ  <= '0;
         mplierQ <= '0;
         accQ    <= '0;
         cntQ    <= '0;
         resultQ <= '0;
         zeroQ   <= 1'b0;
         carryQ  <= 1'b0;
         ovfQ    <= 1'b0;
         errorQ  <= 1'b0;
         doneQ   <= 1'b0;
      end else begin
         stateQ  <= stateD;
         mcandQ  <= mcandD;
         mplierQ <= mplierD;
         accQ    <= accD;
         cntQ    <= cntD;
         resultQ <= resultD;
         zeroQ   <= zeroD;
         carryQ  <= carryD;
         ovfQ    <= ovfD;
         errorQ  <= errorD;
         doneQ   <= doneD;
      end
   end

   assign Result   = resultQ;
   assign Zero     = zeroQ;
   assign Carry    = carryQ;
   assign Overflow = ovfQ;
   assign Error    = errorQ;
   assign Busy     = (stateQ == StMul);
   assign Done     = doneQ;

endmodule
